// File: rtl/sram_stream_ctrl.sv
// Burst-to-SRAM stream initiator: write stream in, read stream out via a 2-entry FIFO.
// Optional SRAM_STREAM_BOUNDS_CHK_EN rejects bursts running past DEPTH (done+err, no access).
module sram_stream_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // WRITE | one SRAM write per accepted write-stream word
    // READ  | issuing reads while FIFO space allows, draining FIFO to the read stream
    // DONE  | one-cycle done (and err) pulse
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [LEN_WIDTH-1:0]  issue_left_q;
    logic [LEN_WIDTH-1:0]  deliver_left_q;
    logic                  err_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wr_ptr, fifo_rd_ptr;
    logic [1:0]            fifo_count;
    logic                  bounds_bad;
    logic                  accept, wr_step, rd_issue, rd_pop, fifo_space;

`ifdef SRAM_STREAM_BOUNDS_CHK_EN
    logic [LEN_WIDTH:0] cmd_end;
    assign cmd_end    = {2'b00, cmd_addr} + {1'b0, cmd_len};
    assign bounds_bad = cmd_end > (LEN_WIDTH+1)'(DEPTH);
`else
    assign bounds_bad = 1'b0;
`endif

    assign addr_nxt   = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
    assign rd_valid   = (fifo_count != 2'd0);
    assign rd_data    = fifo_mem[fifo_rd_ptr];
    assign rd_last    = rd_valid && (deliver_left_q == LEN_WIDTH'(1));
    assign rd_pop     = rd_valid && rd_ready;
    // Count an in-flight read as occupying a FIFO slot so capture never overflows.
    assign fifo_space = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, rd_pop});
    assign sram_addr  = addr_q;
    assign sram_wdata = wr_data;
    assign err        = (state_q == DONE) && err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        wr_step   = 1'b0;
        rd_issue  = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                cmd_ready = rst_n;
                accept    = cmd_valid && rst_n;
                if (accept) begin
                    if (cmd_len == '0 || bounds_bad) state_d = DONE;
                    else if (cmd_write)               state_d = WRITE;
                    else                              state_d = READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                wr_step  = wr_valid;
                sram_en  = wr_valid;
                sram_we  = wr_valid;
                if (wr_valid && issue_left_q == LEN_WIDTH'(1)) state_d = DONE;
            end
            READ: begin
                rd_issue = (issue_left_q != '0) && fifo_space;
                sram_en  = rd_issue;
                if (rd_pop && deliver_left_q == LEN_WIDTH'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            err_q          <= 1'b0;
            inflight_q     <= 1'b0;
            fifo_wr_ptr    <= 1'b0;
            fifo_rd_ptr    <= 1'b0;
            fifo_count     <= 2'd0;
            fifo_mem[0]    <= '0;
            fifo_mem[1]    <= '0;
        end else begin
            if (accept) begin
                addr_q       <= cmd_addr;
                issue_left_q <= cmd_len;
                err_q        <= bounds_bad;
            end else if (wr_step || rd_issue) begin
                addr_q       <= addr_nxt;
                issue_left_q <= issue_left_q - LEN_WIDTH'(1);
            end
            if (accept)      deliver_left_q <= cmd_len;
            else if (rd_pop) deliver_left_q <= deliver_left_q - LEN_WIDTH'(1);
            inflight_q <= rd_issue;
            if (inflight_q) begin
                fifo_mem[fifo_wr_ptr] <= sram_rdata;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (rd_pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight_q} - {1'b0, rd_pop};
        end
    end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Scoreboard bench for sram_stream_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_sram_stream_ctrl;
    localparam int DW = 128;
    localparam int DEPTH = 2048;
    localparam int AW = 11;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          cmd_ready, wr_ready, rd_valid, rd_last;
    logic [DW-1:0] rd_data;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic          busy, done, err;

    sram_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    logic [DW-1:0] exp_rd_d[$];
    logic          exp_rd_l[$];
    int            exp_ra[$];
    int            exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    int n_iss = 0, n_pop = 0, n_done = 0, n_en = 0, exp_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rd_d.delete(); exp_rd_l.delete(); exp_ra.delete();
            n_iss = 0; n_pop = 0;
        end else begin
            if (sram_en) n_en++;
            if (done) n_done++;
            if (sram_en && sram_we) begin
                if (exp_wa.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    chk("wr_addr", DW'(sram_addr), DW'(exp_wa.pop_front()));
                    chk("wr_data", sram_wdata, exp_wd.pop_front());
                end
            end
            if (sram_en && !sram_we) begin
                chk("rd_space", DW'((n_iss - n_pop - int'(rd_valid && rd_ready)) < 2), 1);
                if (exp_ra.size() == 0) chk("rd_issue_extra", 1, 0);
                else chk("rd_addr", DW'(sram_addr), DW'(exp_ra.pop_front()));
                n_iss++;
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_d.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    chk("rd_data", rd_data, exp_rd_d.pop_front());
                    chk("rd_last", DW'(rd_last), DW'(exp_rd_l.pop_front()));
                end
                n_pop++;
            end
        end
    end

    task automatic send_cmd(input logic wr, input int addr, input int len, output int t);
        for (int i = 0; i < 50 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AW'(addr); cmd_len = LW'(len);
        t = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input int addr, input int len, input logic [DW-1:0] base);
        int t;
        for (int i = 0; i < len; i++) begin
            exp_wa.push_back((addr + i) % DEPTH);
            exp_wd.push_back(base + DW'(i));
            ref_mem[(addr + i) % DEPTH] = base + DW'(i);
        end
        send_cmd(1'b1, addr, len, t);
        for (int i = 0; i < len; i++) begin
            wr_valid = 1'b1; wr_data = base + DW'(i);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        exp_done++;
        @(negedge clk);
        chk("wr_done_tN1", DW'(done), 1);
        chk("wr_err", DW'(err), 0);
        chk("wr_left", DW'(exp_wa.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic rd_burst(input int addr, input int len, input bit toggle, input bit timing);
        int t, first, nvalid, tdone;
        bit got_done;
        for (int i = 0; i < len; i++) begin
            exp_ra.push_back((addr + i) % DEPTH);
            exp_rd_d.push_back(ref_mem[(addr + i) % DEPTH]);
            exp_rd_l.push_back(i == len - 1);
        end
        send_cmd(1'b0, addr, len, t);
        first = -1; nvalid = 0; tdone = -1; got_done = 0;
        for (int k = 0; k < 400 && !got_done; k++) begin
            rd_ready = toggle ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (rd_valid) begin
                if (first < 0) first = cyc;
                nvalid++;
            end
            if (done) begin got_done = 1; tdone = cyc; end
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        exp_done++;
        chk("rd_done_seen", DW'(got_done), 1);
        chk("rd_left", DW'(exp_rd_d.size()), 0);
        if (timing) begin
            chk("rd_first_t3", DW'(first), DW'(t + 3));
            chk("rd_valid_cycles", DW'(nvalid), DW'(len));
            chk("rd_done_time", DW'(tdone), DW'(t + len + 3));
        end
    endtask

    initial begin
        int t, en0, d0, hs;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = {96'h5A5A_0000_C0DE_0000_0000, 32'(i * 7 + 3)};
            ref_mem[i]  = {96'h5A5A_0000_C0DE_0000_0000, 32'(i * 7 + 3)};
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cmd_ready", DW'(cmd_ready), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_rd_valid", DW'(rd_valid), 0);
        chk("rst_sram_en", DW'(sram_en), 0);
        chk("rst_wr_ready", DW'(wr_ready), 0);
        chk("rst_done_err", DW'({done, err, rd_last, sram_we}), 0);
        chk("rst_sram_addr", DW'(sram_addr), 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", DW'(cmd_ready), 1);
        @(posedge clk); #1;

        wr_burst(16, 4, 128'hA0);
        rd_burst(16, 4, 1'b0, 1'b1);
        rd_burst(100, 8, 1'b1, 1'b0);
        rd_burst(300, 16, 1'b0, 1'b1);

`ifdef SRAM_STREAM_BOUNDS_CHK_EN
        send_cmd(1'b1, DEPTH - 2, 4, t);
        en0 = n_en;
        exp_done++;
        @(negedge clk);
        chk("oob_done", DW'(done), 1);
        chk("oob_err", DW'(err), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("oob_no_access", DW'(n_en), DW'(en0));
        @(posedge clk); #1;
`else
        wr_burst(DEPTH - 2, 4, 128'hB0);
        rd_burst(DEPTH - 2, 4, 1'b0, 1'b0);
`endif

        send_cmd(1'b1, 5, 0, t);
        en0 = n_en;
        exp_done++;
        @(negedge clk);
        chk("len0_done", DW'(done), 1);
        chk("len0_sram_en", DW'(sram_en), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("len0_cmd_ready", DW'(cmd_ready), 1);
        chk("len0_no_access", DW'(n_en), DW'(en0));
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            exp_ra.push_back(32 + i);
            exp_rd_d.push_back(ref_mem[32 + i]);
            exp_rd_l.push_back(i == 7);
        end
        send_cmd(1'b0, 32, 8, t);
        rd_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 50 && hs < 3; k++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) hs++;
            @(posedge clk); #1;
        end
        chk("rst_mid_hs", DW'(hs), 3);
        rd_ready = 1'b0;
        rst_n = 1'b0;
        d0 = n_done;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_rd_valid", DW'(rd_valid), 0);
        chk("rst_mid_busy", DW'(busy), 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_mid_no_done", DW'(n_done), DW'(d0));
        @(posedge clk); #1;
        rd_burst(16, 4, 1'b0, 1'b1);

        chk("done_pulses", DW'(n_done), DW'(exp_done));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
